// File: rtl/mdu_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package mdu_pkg;

  localparam int unsigned DefaultXlen = 32;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StDone
  } mdu_state_e;

  // Values match the M-extension funct3 encodings.
  typedef enum logic [2:0] {
    OpMul    = 3'd0,
    OpMulh   = 3'd1,
    OpMulhsu = 3'd2,
    OpMulhu  = 3'd3,
    OpDiv    = 3'd4,
    OpDivu   = 3'd5,
    OpRem    = 3'd6,
    OpRemu   = 3'd7
  } mdu_op_e;

  function automatic logic op_is_div(mdu_op_e op);
    return op inside {OpDiv, OpDivu, OpRem, OpRemu};
  endfunction

  function automatic logic op_is_rem(mdu_op_e op);
    return op inside {OpRem, OpRemu};
  endfunction

endpackage

// File: rtl/mdu_sign_ctl.sv
// Operand sign handling for the multiply/divide unit: magnitudes, sign flags and
// detection of the divide cases whose result is known without iterating.
module mdu_sign_ctl
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = DefaultXlen
) (
  input  mdu_op_e         op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] mag_a,
  output logic [XLEN-1:0] mag_b,
  output logic            sign_a,
  output logic            sign_b,
  output logic            fast,
  output logic [XLEN-1:0] fast_res
);

  logic signed_a;
  logic signed_b;
  logic div_zero;
  logic div_ovf;

  always_comb begin
    signed_a = op inside {OpMulh, OpMulhsu, OpDiv, OpRem};
    signed_b = op inside {OpMulh, OpDiv, OpRem};

    sign_a = signed_a & a[XLEN-1];
    sign_b = signed_b & b[XLEN-1];
    mag_a  = sign_a ? ({XLEN{1'b0}} - a) : a;
    mag_b  = sign_b ? ({XLEN{1'b0}} - b) : b;

    div_zero = op_is_div(op) & (b == {XLEN{1'b0}});
    // Most-negative dividend over -1 overflows the signed quotient.
    div_ovf  = (op inside {OpDiv, OpRem}) & (a == {1'b1, {(XLEN-1){1'b0}}}) &
               (b == {XLEN{1'b1}});

    fast     = div_zero | div_ovf;
    fast_res = {XLEN{1'b0}};
    if (div_zero) begin
      fast_res = op_is_rem(op) ? a : {XLEN{1'b1}};
    end else if (div_ovf) begin
      fast_res = op_is_rem(op) ? {XLEN{1'b0}} : a;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring
// divide, stalling the pipeline while busy and holding a registered result.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = DefaultXlen
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN);

  mdu_state_e        state_q, state_d;
  mdu_op_e           op_q, op_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_b_q, sign_b_d;
  logic [XLEN-1:0]   opnd_q, opnd_d;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN:0]     rem_q, rem_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [XLEN-1:0]   result_q, result_d;

  mdu_op_e         op_in;
  logic [XLEN-1:0] mag_a;
  logic [XLEN-1:0] mag_b;
  logic            sign_a;
  logic            sign_b;
  logic            fast;
  logic [XLEN-1:0] fast_res;

  assign op_in = mdu_op_e'(funct3);

  mdu_sign_ctl #(
    .XLEN (XLEN)
  ) u_sign_ctl (
    .op       (op_in),
    .a        (op_a),
    .b        (op_b),
    .mag_a    (mag_a),
    .mag_b    (mag_b),
    .sign_a   (sign_a),
    .sign_b   (sign_b),
    .fast     (fast),
    .fast_res (fast_res)
  );

  // One iteration of each datapath, evaluated from the current registers.
  logic [XLEN:0]     mul_sum;
  logic [2*XLEN-1:0] mul_acc;
  logic [XLEN:0]     div_shift;
  logic [XLEN:0]     div_diff;
  logic [XLEN:0]     div_rem;
  logic [XLEN-1:0]   div_quo;
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   final_res;

  always_comb begin
    // Multiplier sits in the low half and shifts out as the product shifts in.
    mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    mul_acc = {mul_sum, acc_q[XLEN-1:1]};

    // Low half holds the dividend, shifted out MSB-first while quotient bits enter.
    div_shift = {rem_q[XLEN-1:0], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, opnd_q};
    if (!div_diff[XLEN]) begin
      div_rem = div_diff;
      div_quo = {acc_q[XLEN-2:0], 1'b1};
    end else begin
      div_rem = div_shift;
      div_quo = {acc_q[XLEN-2:0], 1'b0};
    end

    prod_fix = (sign_a_q ^ sign_b_q) ? ({(2*XLEN){1'b0}} - mul_acc) : mul_acc;
    quo_fix  = (sign_a_q ^ sign_b_q) ? ({XLEN{1'b0}} - div_quo) : div_quo;
    rem_fix  = sign_a_q ? ({XLEN{1'b0}} - div_rem[XLEN-1:0]) : div_rem[XLEN-1:0];

    unique case (op_q)
      OpMul:                     final_res = prod_fix[XLEN-1:0];
      OpMulh, OpMulhsu, OpMulhu: final_res = prod_fix[2*XLEN-1:XLEN];
      OpDiv, OpDivu:             final_res = quo_fix;
      default:                   final_res = rem_fix;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    opnd_d   = opnd_q;
    acc_d    = acc_q;
    rem_d    = rem_q;
    count_d  = count_q;
    result_d = result_q;

    unique case (state_q)
      StIdle: begin
        if (start && !flush) begin
          op_d     = op_in;
          sign_a_d = sign_a;
          sign_b_d = sign_b;
          opnd_d   = op_is_div(op_in) ? mag_b : mag_a;
          acc_d    = {{XLEN{1'b0}}, (op_is_div(op_in) ? mag_a : mag_b)};
          rem_d    = {(XLEN+1){1'b0}};
          count_d  = {CntW{1'b0}};
          if (fast) begin
            result_d = fast_res;
            state_d  = StDone;
          end else begin
            state_d = StCalc;
          end
        end
      end
      StCalc: begin
        count_d = count_q + 1'b1;
        if (op_is_div(op_q)) begin
          acc_d = {{XLEN{1'b0}}, div_quo};
          rem_d = div_rem;
        end else begin
          acc_d = mul_acc;
        end
        if (count_q == CntW'(XLEN - 1)) begin
          result_d = final_res;
          state_d  = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // A squash abandons the instruction and leaves the last result untouched.
    if (flush) begin
      state_d  = StIdle;
      result_d = result_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      op_q     <= OpMul;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      opnd_q   <= {XLEN{1'b0}};
      acc_q    <= {(2*XLEN){1'b0}};
      rem_q    <= {(XLEN+1){1'b0}};
      count_q  <= {CntW{1'b0}};
      result_q <= {XLEN{1'b0}};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      opnd_q   <= opnd_d;
      acc_q    <= acc_d;
      rem_q    <= rem_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  assign busy   = (state_q == StCalc);
  assign done   = (state_q == StDone) && !flush;
  assign stall  = ((state_q == StIdle) && start && !flush) || (state_q == StCalc);
  assign result = result_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed self-checking bench for mul_div_unit with hand-computed expectations.
module tb_mul_div_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int n_assert;
  int n_fail;

  mul_div_unit #(
    .XLEN (32)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .funct3 (funct3),
    .op_a   (op_a),
    .op_b   (op_b),
    .flush  (flush),
    .stall  (stall),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one op in cycle 0 and checks done cycle, result and stalled-cycle count.
  task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input bit hold, input logic [31:0] exp_res,
                        input int exp_lat);
    int stall_cnt;
    int done_cyc;
    @(negedge clk);
    funct3 = f;
    op_a   = a;
    op_b   = b;
    start  = 1'b1;
    #1;
    stall_cnt = stall ? 1 : 0;
    done_cyc  = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (stall) stall_cnt++;
      if (done) begin
        done_cyc = cyc;
        break;
      end
      if (!hold) start = 1'b0;
    end
    check($sformatf("%s_done_cycle", tag), done_cyc, exp_lat);
    check($sformatf("%s_result", tag), result, exp_res);
    check($sformatf("%s_stall_cycles", tag), stall_cnt, exp_lat);
    start = 1'b0;
  endtask

  task automatic watch_no_done(input string tag, input int n);
    int cnt;
    cnt = 0;
    repeat (n) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check(tag, cnt, 0);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset    = 1'b1;
    start    = 1'b0;
    flush    = 1'b0;
    funct3   = 3'd0;
    op_a     = 32'd0;
    op_b     = 32'd0;
    #12;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_stall", stall, 0);
    check("rst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;

    run_op("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 33);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFE, 33);
    run_op("mulhsu_-1x2", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0, 32'hFFFF_FFFF, 33);
    run_op("mulh_min_sq", 3'd1, 32'h8000_0000, 32'h8000_0000, 1'b0, 32'h4000_0000, 33);
    run_op("div_-7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFD, 33);
    run_op("rem_-7_2", 3'd6, 32'hFFFF_FFF9, 32'd2, 1'b0, 32'hFFFF_FFFF, 33);
    run_op("divu_100_7", 3'd5, 32'd100, 32'd7, 1'b0, 32'd14, 33);
    run_op("remu_100_7", 3'd7, 32'd100, 32'd7, 1'b0, 32'd2, 33);

    run_op("div_by_zero", 3'd4, 32'h0000_1234, 32'd0, 1'b0, 32'hFFFF_FFFF, 1);
    run_op("remu_by_zero", 3'd7, 32'd5, 32'd0, 1'b0, 32'd5, 1);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h8000_0000, 1);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 32'h0, 1);

    // Flush in cycle 10 of a multiply that follows a known result.
    run_op("divu_pre_flush", 3'd5, 32'd100, 32'd7, 1'b0, 32'd14, 33);
    @(negedge clk);
    funct3 = 3'd0;
    op_a   = 32'd7;
    op_b   = 32'hFFFF_FFFD;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("flush_busy_before", busy, 1);
    flush = 1'b1;
    #1;
    check("flush_done_gated", done, 0);
    @(negedge clk);
    flush = 1'b0;
    check("flush_busy_after", busy, 0);
    check("flush_stall_after", stall, 0);
    check("flush_result_kept", result, 32'd14);
    watch_no_done("flush_no_done", 40);
    run_op("remu_post_flush", 3'd7, 32'd100, 32'd7, 1'b0, 32'd2, 33);

    // Asynchronous reset in the middle of CALC.
    @(negedge clk);
    funct3 = 3'd5;
    op_a   = 32'd100;
    op_b   = 32'd7;
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (5) @(negedge clk);
    check("midrst_busy_before", busy, 1);
    reset = 1'b1;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_done", done, 0);
    check("midrst_stall", stall, 0);
    check("midrst_result", result, 32'h0);
    @(negedge clk);
    reset = 1'b0;
    watch_no_done("midrst_no_done", 40);

    // start held through CALC and the DONE cycle: no restart, single done.
    run_op("div_hold_start", 3'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 32'hFFFF_FFFD, 33);
    watch_no_done("hold_no_second_done", 40);
    check("hold_idle_busy", busy, 0);
    check("hold_result_kept", result, 32'hFFFF_FFFD);

    run_op("mul_after_all", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0, 32'hFFFF_FFEB, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within the time limit");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Iterative RV32M multiply/divide unit in the EX stage, directly downstream of the forwarding unit: its operands are the already-forwarded rs1/rs2 values selected by the ForwardA/ForwardB muxes. It executes MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU with a fixed 32-iteration shift-add or restoring-divide datapath. It drives a stall to the hazard logic while busy and presents a registered 32-bit result for the EX/MEM register.

## Interface
Parameters:
- XLEN, 32, operand/result width; the iteration count equals XLEN.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- start  in  1  EX holds an M-extension instruction; sampled only in IDLE.
- funct3  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  in  XLEN  forwarded rs1 value (dividend / multiplicand).
- op_b  in  XLEN  forwarded rs2 value (divisor / multiplier).
- flush  in  1  branch/exception squash of the EX instruction.
- stall  out  1  freeze IF/ID/EX; combinational.
- busy  out  1  state is CALC.
- done  out  1  one-cycle pulse; result valid.
- result  out  XLEN  registered result, held until the next accepted start.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - start=1 and flush=0: latch funct3, operands, and sign flags.
  - Signed ops (MULH; DIV/REM; op_a only for MULHSU) convert operands to magnitudes.
  - Count=0, then go to CALC.
- IDLE fast path: the following go straight to DONE with their results latched.
  - Divide by zero (op_b=0): DIV/DIVU give all-ones; REM/REMU give op_a.
  - Signed overflow (DIV/REM, op_a=0x80000000, op_b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per cycle.
  - Multiply: radix-2 shift-add into a 2·XLEN accumulator.
  - Divide: restoring step with a XLEN+1-bit partial remainder.
  - After iteration XLEN-1 (count wraps to 0), apply the sign fix, register result, go to DONE.
- Sign fix:
  - Product is negated iff sign_a^sign_b.
  - Quotient is negated iff sign_a^sign_b.
  - Remainder takes the sign of the dividend.
  - MUL takes the low XLEN bits; MULH* take the high XLEN bits.
- DONE: done=1, then go to IDLE on the next edge.
  - A start in that same cycle is the next instruction and is ignored; it is accepted from IDLE one cycle later.
- flush: has priority over everything.
  - In CALC or DONE it forces IDLE on the next edge with no done pulse; result keeps its old value.
  - In IDLE with start, it blocks acceptance.
- start asserted in CALC is ignored.
- stall = (IDLE & start & ~flush) | CALC.
  - stall is 0 in DONE, so the pipeline advances the same cycle result is valid.

## Timing
- Reset values: state IDLE, busy 0, done 0, stall 0 (unless start is high), result 0, count 0.
- Normal latency: start in cycle 0 → CALC in cycles 1..32 → done=1 and result valid in cycle 33.
- stall is high in cycles 0..32.
- Fast path: start in cycle 0 → done in cycle 1; stall is high in cycle 0 only.
- reset mid-CALC: outputs go to reset values immediately (asynchronous); there is no done pulse.
- result changes only on the edge entering DONE.

## Structure
- Shared package mdu_pkg holds:
  - the mdu_state_e enum (IDLE, CALC, DONE);
  - the mdu_op_e enum of the funct3 encodings above;
  - the XLEN default constant.
- One sub-module, mdu_sign_ctl (combinational). Inputs: op, raw operands. Outputs: magnitudes, sign flags, and fast-path detection with its result.
- The iteration datapath and FSM stay in mul_div_unit.

## Test plan
- MUL 7×(−3), funct3=0 → done in cycle 33, result 0xFFFFFFEB; stall high cycles 0..32.
- MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE; MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV −7/2 → 0xFFFFFFFD; REM −7/2 → 0xFFFFFFFF; DIVU 100/7 → 14; REMU → 2.
- DIV x/0 → 0xFFFFFFFF and REMU 5/0 → 5; DIV 0x80000000/−1 → 0x80000000. All fast-path cases give done in cycle 1.
- Flush in cycle 10 of CALC → IDLE at the next edge, no done pulse, result unchanged; a following start is accepted normally.
- Reset asserted mid-CALC, start held high in CALC, and start held high in the DONE cycle:
  - reset clears all outputs asynchronously;
  - ignored starts cause no restart and no second done pulse.
